decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, giving the program-counter width.
REQ-002 SHALL have parameter CNT_W, default 8, giving the illegal-instruction counter width.
REQ-003 i_clk  in  1  sole clock, rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_flush  in  1  discard all buffered entries.
REQ-006 i_valid / o_ready  in / out  1 / 1  upstream handshake.
REQ-007 i_instr / i_pc  in  32 / PC_W  instruction word and its PC.
REQ-008 o_valid / i_ready  out / in  1 / 1  downstream handshake.
REQ-009 o_pc, o_rs1, o_rd, o_rs2  out  PC_W, 5, 5, 5  PC and register indices of the head entry.
REQ-010 o_imm  out  32  sign-extended immediate of the head entry.
REQ-011 o_legal, o_branch, o_jump, o_rf_we, o_lsu_we  out  1 each  control flags of the head entry.
REQ-012 o_alusel1, o_alusel2, o_wb_sel  out  2 each  selectors, encoded per the shared decoder header.
REQ-013 o_alu_op  out  5  ALU operation, with the header codes zero-extended to 5 bits.
REQ-014 o_cmp_op, o_lsu_size  out  3 / 3  compare op per the header; funct3 for loads and stores.
REQ-015 o_trap, o_trap_pc, o_trap_instr  out  1, PC_W, 32  sticky first-illegal record.
REQ-016 i_trap_clr  in  1  clears the trap record.
REQ-017 o_illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

Function
REQ-018 SHALL decode i_instr combinationally at input and store the full decoded bundle in a 2-entry in-order FIFO; the outputs SHALL show the head entry.
REQ-019 Push SHALL occur on i_valid&&o_ready; pop SHALL occur on o_valid&&i_ready; push and pop in the same cycle SHALL be legal.
REQ-020 o_ready SHALL be a registered flag equal to (count<2) and SHALL have no combinational path from i_ready.
REQ-021 Latency SHALL be one cycle: an entry pushed at edge N into an empty FIFO SHALL be visible with o_valid=1 after edge N.
REQ-022 When the FIFO is full and a pop occurs, count SHALL become 1 and o_ready SHALL be 1 after that edge.
REQ-023 Head outputs SHALL hold stable while o_valid&&!i_ready.
REQ-024 i_flush SHALL set count to 0, discard any same-cycle push, deassert o_valid next cycle, and leave trap state and counter unchanged.
REQ-025 Legal set: LUI; AUIPC; JAL (any bits 14:12); JALR with funct3=000; branches with funct3 in {000,001,100,101,110,111}; loads with funct3 in {000,001,010,100,101}; stores with funct3 in {000,001,010}.
REQ-026 Legal set, continued: OP-IMM with SLLI imm[11:5]=0000000, SRLI imm[11:5]=0000000, SRAI imm[11:5]=0100000; OP with funct7 0000000, or 0100000 for SUB/SRA only.
REQ-027 Any instr[1:0]!=11 and every other opcode (FENCE and SYSTEM included) SHALL be illegal.
REQ-028 An illegal entry SHALL have o_legal=0, o_rf_we=o_lsu_we=o_branch=o_jump=0, o_alu_op=ALU_OP_INV and o_cmp_op=CBU_OP_INV.
REQ-029 Illegal entries SHALL still be enqueued and delivered downstream.
REQ-030 o_imm SHALL select by format: I, S, B (bit0=0), U (low 12 bits 0) or J (bit0=0), each sign-extended from instr[31]; R-type and illegal SHALL give 0.
REQ-031 On push of an illegal instruction while o_trap=0: o_trap SHALL be 1 next cycle, with i_pc and i_instr captured; later illegals SHALL NOT overwrite the record.
REQ-032 i_trap_clr SHALL clear o_trap; if it coincides with an illegal push, the new capture SHALL win and o_trap SHALL remain 1.
REQ-033 o_illegal_cnt SHALL increment per illegal push, saturate at all-ones, and be cleared only by reset.

Reset
REQ-034 While i_rst_n=0: count=0, o_valid=0, o_ready=0, all head outputs 0, o_trap=0, o_trap_pc=0, o_trap_instr=0, o_illegal_cnt=0.
REQ-035 o_ready SHALL rise on the first clock edge after i_rst_n deasserts.
REQ-036 Reset asserted mid-transfer SHALL drop all entries immediately and asynchronously.

Configuration
REQ-037 Macro DECODE_STAGE_RV32M_EN defined: OP with funct7=0000001 SHALL be legal, with o_alu_op 5'h10..5'h17 for funct3 000..111 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-038 Macro undefined: funct7=0000001 SHALL be illegal, and o_alu_op[4] SHALL be tied to 0.

Verification
REQ-039 Bench SHALL cover: push 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle o_valid=1, o_alu_op=ALU_OP_ADD, o_rd=1, o_imm=5, o_legal=1.
REQ-040 Bench SHALL cover: hold i_ready=0 and push 3 instructions -> o_ready=0 after the 2nd; release i_ready -> order preserved, 3rd accepted.
REQ-041 Bench SHALL cover: push 0xFFFFFFFF at pc 0x200 then 0x00000000 at 0x204 -> o_trap=1, o_trap_pc=0x200, o_illegal_cnt=2, both delivered with rf_we=0.
REQ-042 Bench SHALL cover: i_flush with 2 entries and a concurrent push -> o_valid=0 next cycle, trap and counter unchanged.
REQ-043 Bench SHALL cover: 0x02208033 (mul) -> alu_op 5'h10 legal with DECODE_STAGE_RV32M_EN, illegal without it.
REQ-044 Bench SHALL cover: 300 illegal pushes with CNT_W=8 -> o_illegal_cnt=255.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a 2-entry in-order FIFO, plus sticky trap record and illegal counter.
// Optional feature: define DECODE_STAGE_RV32M_EN to accept the RV32M multiply/divide group.
module decode_stage #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [PC_W-1:0]  i_pc,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PC_W-1:0]  o_pc,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs2,
  output logic [31:0]      o_imm,
  output logic             o_legal,
  output logic             o_branch,
  output logic             o_jump,
  output logic             o_rf_we,
  output logic             o_lsu_we,
  output logic [1:0]       o_alusel1,
  output logic [1:0]       o_alusel2,
  output logic [1:0]       o_wb_sel,
  output logic [4:0]       o_alu_op,
  output logic [2:0]       o_cmp_op,
  output logic [2:0]       o_lsu_size,
  output logic             o_trap,
  output logic [PC_W-1:0]  o_trap_pc,
  output logic [31:0]      o_trap_instr,
  input  logic             i_trap_clr,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  // Shared decoder encodings
  localparam logic [3:0] ALU_OP_ADD  = 4'h0, ALU_OP_SUB = 4'h1, ALU_OP_SLL = 4'h2,
                         ALU_OP_SLT  = 4'h3, ALU_OP_SLTU = 4'h4, ALU_OP_XOR = 4'h5,
                         ALU_OP_SRL  = 4'h6, ALU_OP_SRA = 4'h7, ALU_OP_OR  = 4'h8,
                         ALU_OP_AND  = 4'h9, ALU_OP_INV = 4'hF;
  localparam logic [2:0] CBU_OP_NONE = 3'b010, CBU_OP_INV = 3'b011;
  localparam logic [1:0] ALUSEL1_RS1 = 2'd0, ALUSEL1_PC = 2'd1, ALUSEL1_ZERO = 2'd2;
  localparam logic [1:0] ALUSEL2_RS2 = 2'd0, ALUSEL2_IMM = 2'd1;
  localparam logic [1:0] WB_ALU = 2'd0, WB_LSU = 2'd1, WB_PC4 = 2'd2;

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F,
                         OPC_JALR = 7'h67, OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03,
                         OPC_STORE = 7'h23, OPC_OPIMM = 7'h13, OPC_OP = 7'h33;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            legal;
    logic            branch;
    logic            jump;
    logic            rf_we;
    logic            lsu_we;
    logic [1:0]      alusel1;
    logic [1:0]      alusel2;
    logic [1:0]      wb_sel;
    logic [4:0]      alu_op;
    logic [2:0]      cmp_op;
    logic [2:0]      lsu_size;
  } entry_t;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_OP_ADD;
      3'b001:  return ALU_OP_SLL;
      3'b010:  return ALU_OP_SLT;
      3'b011:  return ALU_OP_SLTU;
      3'b100:  return ALU_OP_XOR;
      3'b101:  return ALU_OP_SRL;
      3'b110:  return ALU_OP_OR;
      default: return ALU_OP_AND;
    endcase
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  alu4;
`ifdef DECODE_STAGE_RV32M_EN
  logic        mext;
`endif
  entry_t      dec;

  assign opc   = i_instr[6:0];
  assign f3    = i_instr[14:12];
  assign f7    = i_instr[31:25];
  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'h000};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    dec.pc     = i_pc;
    dec.rs1    = i_instr[19:15];
    dec.rd     = i_instr[11:7];
    dec.rs2    = i_instr[24:20];
    dec.cmp_op = CBU_OP_NONE;
    alu4       = ALU_OP_ADD;
`ifdef DECODE_STAGE_RV32M_EN
    mext       = 1'b0;
`endif
    case (opc)
      OPC_LUI: begin
        dec.legal = 1'b1; dec.rf_we = 1'b1; dec.imm = imm_u;
        dec.alusel1 = ALUSEL1_ZERO; dec.alusel2 = ALUSEL2_IMM;
      end
      OPC_AUIPC: begin
        dec.legal = 1'b1; dec.rf_we = 1'b1; dec.imm = imm_u;
        dec.alusel1 = ALUSEL1_PC; dec.alusel2 = ALUSEL2_IMM;
      end
      OPC_JAL: begin
        dec.legal = 1'b1; dec.rf_we = 1'b1; dec.jump = 1'b1; dec.imm = imm_j;
        dec.alusel1 = ALUSEL1_PC; dec.alusel2 = ALUSEL2_IMM; dec.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        dec.legal = (f3 == 3'b000); dec.rf_we = 1'b1; dec.jump = 1'b1; dec.imm = imm_i;
        dec.alusel1 = ALUSEL1_RS1; dec.alusel2 = ALUSEL2_IMM; dec.wb_sel = WB_PC4;
      end
      OPC_BRANCH: begin
        dec.legal = (f3 != 3'b010) && (f3 != 3'b011); dec.branch = 1'b1; dec.imm = imm_b;
        dec.alusel1 = ALUSEL1_PC; dec.alusel2 = ALUSEL2_IMM; dec.cmp_op = f3;
      end
      OPC_LOAD: begin
        dec.legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        dec.rf_we = 1'b1; dec.imm = imm_i; dec.alusel2 = ALUSEL2_IMM;
        dec.wb_sel = WB_LSU; dec.lsu_size = f3;
      end
      OPC_STORE: begin
        dec.legal = (f3 < 3'b011); dec.lsu_we = 1'b1; dec.imm = imm_s;
        dec.alusel2 = ALUSEL2_IMM; dec.lsu_size = f3;
      end
      OPC_OPIMM: begin
        dec.rf_we = 1'b1; dec.imm = imm_i; dec.alusel2 = ALUSEL2_IMM;
        alu4 = alu_from_f3(f3);
        if (f3 == 3'b001)      dec.legal = (f7 == 7'h00);
        else if (f3 == 3'b101) begin
          dec.legal = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) alu4 = ALU_OP_SRA;
        end
        else                   dec.legal = 1'b1;
      end
      OPC_OP: begin
        dec.rf_we = 1'b1; dec.alusel2 = ALUSEL2_RS2;
        alu4 = alu_from_f3(f3);
        if (f7 == 7'h00) dec.legal = 1'b1;
        else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec.legal = 1'b1;
          alu4 = (f3 == 3'b000) ? ALU_OP_SUB : ALU_OP_SRA;
        end
`ifdef DECODE_STAGE_RV32M_EN
        else if (f7 == 7'h01) begin
          dec.legal = 1'b1;
          mext = 1'b1;
        end
`endif
      end
      default: ;
    endcase
`ifdef DECODE_STAGE_RV32M_EN
    dec.alu_op = mext ? {2'b10, f3} : {1'b0, alu4};
`else
    dec.alu_op = {1'b0, alu4};
`endif
    if (!dec.legal) begin
      dec.imm = '0; dec.branch = 1'b0; dec.jump = 1'b0; dec.rf_we = 1'b0; dec.lsu_we = 1'b0;
      dec.alusel1 = '0; dec.alusel2 = '0; dec.wb_sel = '0; dec.lsu_size = '0;
      dec.alu_op = {1'b0, ALU_OP_INV};
      dec.cmp_op = CBU_OP_INV;
    end
  end

  // Slot 0 is always the head; a pop shifts slot 1 down
  entry_t     slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       ready_q;
  logic       push, pop;

  assign push = i_valid && ready_q && !i_flush;
  assign pop  = (count_q != 2'd0) && i_ready;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (i_flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = dec;
          else                 slot1_d = dec;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) slot0_d = dec;
          else begin
            slot0_d = slot1_q;
            slot1_d = dec;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
      ready_q <= (count_d < 2'd2);
    end
  end

  logic             trap_q;
  logic [PC_W-1:0]  trap_pc_q;
  logic [31:0]      trap_instr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ill;

  assign push_ill = push && !dec.legal;

  // A clear coinciding with an illegal push lets the new capture win
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trap_q       <= 1'b0;
      trap_pc_q    <= '0;
      trap_instr_q <= '0;
      cnt_q        <= '0;
    end else begin
      if (push_ill && (!trap_q || i_trap_clr)) begin
        trap_q       <= 1'b1;
        trap_pc_q    <= i_pc;
        trap_instr_q <= i_instr;
      end else if (i_trap_clr) begin
        trap_q <= 1'b0;
      end
      if (push_ill && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = (count_q != 2'd0);
  assign o_pc          = slot0_q.pc;
  assign o_rs1         = slot0_q.rs1;
  assign o_rd          = slot0_q.rd;
  assign o_rs2         = slot0_q.rs2;
  assign o_imm         = slot0_q.imm;
  assign o_legal       = slot0_q.legal;
  assign o_branch      = slot0_q.branch;
  assign o_jump        = slot0_q.jump;
  assign o_rf_we       = slot0_q.rf_we;
  assign o_lsu_we      = slot0_q.lsu_we;
  assign o_alusel1     = slot0_q.alusel1;
  assign o_alusel2     = slot0_q.alusel2;
  assign o_wb_sel      = slot0_q.wb_sel;
  assign o_alu_op      = slot0_q.alu_op;
  assign o_cmp_op      = slot0_q.cmp_op;
  assign o_lsu_size    = slot0_q.lsu_size;
  assign o_trap        = trap_q;
  assign o_trap_pc     = trap_pc_q;
  assign o_trap_instr  = trap_instr_q;
  assign o_illegal_cnt = cnt_q;

endmodule
